// File: rtl/soc_system_led_pio_if.sv
// Avalon-MM slave bus bundle for the LED PIO: word address, select, active-low write and 32-bit data.
`timescale 1ns/1ps
interface soc_system_led_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_system_led_pio.sv
// LED PIO: DATA/OUTSET/OUTCLEAR registers, registered pins and readback, with an optional
// blink engine compiled in only when SOC_SYSTEM_LED_PIO_BLINK_EN is defined.
`timescale 1ns/1ps
module soc_system_led_pio #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    soc_system_led_pio_if.slave   avs,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_PINS   = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_PERIOD = 3'd3;
    localparam logic [2:0] ADDR_SET    = 3'd4;
    localparam logic [2:0] ADDR_CLR    = 3'd5;

    function automatic logic [31:0] zext(input logic [DATA_WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[DATA_WIDTH-1:0] = v;
        return r;
    endfunction

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  unused_wdata;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [31:0]           readdata_q, readdata_d;

    assign wr_en        = avs.chipselect & ~avs.write_n;
    assign wdata        = avs.writedata[DATA_WIDTH-1:0];
    assign unused_wdata = ^avs.writedata;

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (avs.address)
                ADDR_DATA: data_d = wdata;
                ADDR_SET:  data_d = data_q | wdata;
                ADDR_CLR:  data_d = data_q & ~wdata;
                default:   data_d = data_q;
            endcase
        end
    end

`ifdef SOC_SYSTEM_LED_PIO_BLINK_EN
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [23:0]           period_q, period_d;
    logic [23:0]           cnt_q, cnt_d;
    logic                  phase_q, phase_d;

    // A period write restarts the blink cycle and wins over a coincident wrap.
    always_comb begin
        mask_d   = mask_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        if (wr_en && avs.address == ADDR_MASK)
            mask_d = wdata;
        if (wr_en && avs.address == ADDR_PERIOD) begin
            period_d = avs.writedata[23:0];
            cnt_d    = '0;
            phase_d  = 1'b0;
        end else if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period_q) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q   <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    assign out_d = data_q ^ (mask_q & {DATA_WIDTH{phase_q}});
`else
    assign out_d = data_q;
`endif

    always_comb begin
        readdata_d = '0;
        case (avs.address)
            ADDR_DATA:   readdata_d = zext(data_q);
            ADDR_PINS:   readdata_d = zext(out_q);
`ifdef SOC_SYSTEM_LED_PIO_BLINK_EN
            ADDR_MASK:   readdata_d = zext(mask_q);
            ADDR_PERIOD: readdata_d = {8'd0, period_q};
`endif
            default:     readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            out_q      <= RESET_VALUE;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            out_q      <= out_d;
            readdata_q <= readdata_d;
        end
    end

    assign avs.readdata = readdata_q;
    assign out_port     = out_q;

endmodule

// File: tb/tb_soc_system_led_pio.sv
// Directed bench for soc_system_led_pio (RESET_VALUE=8'hA5); blink checks follow SOC_SYSTEM_LED_PIO_BLINK_EN.
`timescale 1ns/1ps
module tb_soc_system_led_pio;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] out_port;
    int         checks   = 0;
    int         failures = 0;

    soc_system_led_pio_if bus ();

    soc_system_led_pio #(
        .DATA_WIDTH  (8),
        .RESET_VALUE (8'hA5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .avs      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        @(posedge clk); #1;
        d = bus.readdata;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        #2 reset = 1'b1;
        #1;
        check("rst_out", 32'(out_port), 32'h0000_00A5);
        check("rst_rdata", bus.readdata, 32'h0);
        idle(2);
        check("rst_out_clk", 32'(out_port), 32'h0000_00A5);
        check("rst_rdata_clk", bus.readdata, 32'h0);
        reset = 1'b0;

        bus_rd(3'd0, rd);
        check("post_rst_data", rd, 32'h0000_00A5);
        check("post_rst_out", 32'(out_port), 32'h0000_00A5);

        // DATA, OUTSET, OUTCLEAR back to back; pins follow one cycle behind.
        bus_wr(3'd0, 32'h0F);
        bus_wr(3'd4, 32'hF0);
        check("out_after_data", 32'(out_port), 32'h0F);
        bus_wr(3'd5, 32'h81);
        check("out_after_set", 32'(out_port), 32'hFF);
        idle(1);
        check("out_after_clr", 32'(out_port), 32'h7E);

        bus_wr(3'd0, 32'hFFFF_FF3C);
        bus_rd(3'd0, rd);
        check("data_trunc", rd, 32'h0000_003C);
        bus_rd(3'd1, rd);
        check("pins_read", rd, 32'h0000_003C);
        bus_rd(3'd5, rd);
        check("outclr_read0", rd, 32'h0);
        bus_rd(3'd7, rd);
        check("rsvd_read0", rd, 32'h0);

        bus_wr(3'd1, 32'h12);
        bus_wr(3'd6, 32'h34);
        bus_rd(3'd0, rd);
        check("noop_wr_data", rd, 32'h3C);

        bus.address    = 3'd0;
        bus.writedata  = 32'h99;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b0;
        idle(1);
        bus.write_n    = 1'b1;
        bus_rd(3'd0, rd);
        check("nocs_wr_data", rd, 32'h3C);
        check("nocs_wr_out", 32'(out_port), 32'h3C);

`ifdef SOC_SYSTEM_LED_PIO_BLINK_EN
        bus_wr(3'd0, 32'h00);
        bus_wr(3'd2, 32'h01);
        bus_rd(3'd2, rd);
        check("mask_read", rd, 32'h01);
        bus_wr(3'd3, 32'hFF00_0003);
        // Phase toggles every 4 edges after the period write; pins lag by one edge.
        for (int i = 1; i <= 16; i++) begin
            idle(1);
            check($sformatf("blink_%0d", i), 32'(out_port), 32'(((i - 1) / 4) % 2));
        end
        idle(3);
        bus_wr(3'd3, 32'h3);
        for (int i = 1; i <= 8; i++) begin
            idle(1);
            check($sformatf("wrap_wr_%0d", i), 32'(out_port), 32'(((i - 1) / 4) % 2));
        end
        bus_rd(3'd3, rd);
        check("period_read", rd, 32'h3);

        idle(5);
        reset = 1'b1;
        #1;
        check("midblink_rst_out", 32'(out_port), 32'hA5);
        idle(1);
        reset = 1'b0;
        bus_rd(3'd3, rd);
        check("period_after_rst", rd, 32'h0);
        idle(8);
        check("no_blink_after_rst", 32'(out_port), 32'hA5);
`else
        bus_wr(3'd2, 32'h55);
        bus_rd(3'd2, rd);
        check("mask_absent_read", rd, 32'h0);
        check("mask_absent_out", 32'(out_port), 32'h3C);
        bus_wr(3'd3, 32'h3);
        bus_rd(3'd3, rd);
        check("period_absent_read", rd, 32'h0);
        idle(10);
        check("no_blink_out", 32'(out_port), 32'h3C);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
